// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbitration logic.
package uart_pkg;

    // Width of one UART data byte.
    localparam int UART_DATA_W = 8;

    // Default watchdog budget in clk cycles; comfortably longer than one frame.
    localparam int DEFAULT_TIMEOUT = 20000;

    // Arbiter states: pick a winner, start the frame, wait for it, hand back.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SEND    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: scans req upward from rr_ptr with
// wrap-around and reports the first set bit. Kept free of arbiter state so
// an RX-side dispatcher can reuse it.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             valid,
    output logic [ID_W-1:0]  winner
);

    // One extra bit so rr_ptr + offset cannot overflow before the wrap.
    logic [ID_W:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (cand >= (ID_W + 1)'(N_REQ)) begin
                cand = cand - (ID_W + 1)'(N_REQ);
            end
            if (req[cand[ID_W-1:0]]) begin
                valid  = 1'b1;
                winner = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte
// producers. Grants one requester, holds its byte and enable on the
// transmitter until tx_done, acks the winner and rotates priority. A
// watchdog abandons a frame whose tx_done never arrives; the requester
// is then left pending and retried on its next round-robin turn.
//
// Handshake: a producer raises req[i] with its byte stable on data; the
// arbiter answers with a one-cycle ack[i] once that byte is sent. The
// producer holds req/data until ack and may keep req high to queue more.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int ID_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [UART_DATA_W*N_REQ-1:0] data,
    output logic [N_REQ-1:0]             ack,
    output logic [UART_DATA_W-1:0]       tx_data,
    output logic                         tx_enable,
    input  logic                         tx_done,
    output logic [ID_W-1:0]              grant_id,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   tx_enable_q, tx_enable_d;
    logic [N_REQ-1:0]       ack_q, ack_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [WD_W-1:0]        wd_q, wd_d;

    logic                   pick_valid;
    logic [ID_W-1:0]        pick_winner;
    logic [UART_DATA_W-1:0] pick_byte;
    logic [N_REQ-1:0]       grant_onehot;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    // Select the candidate winner's byte from the packed data bus.
    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_winner == ID_W'(i)) begin
                pick_byte = data[i*UART_DATA_W +: UART_DATA_W];
            end
        end
    end

    // Decode the registered grant into a one-hot ack pattern.
    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_onehot[i] = (grant_id_q == ID_W'(i));
        end
    end

    // Next-state and next-output logic for the IDLE/LOAD/SEND/RELEASE cycle.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        tx_enable_d   = tx_enable_q;
        ack_d         = '0;
        timeout_err_d = timeout_err_q;
        wd_d          = wd_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_id_d = pick_winner;
                    tx_data_d  = pick_byte;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wd_d        = '0;
                tx_enable_d = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                wd_d = wd_q + 1'b1;
                // A tx_done arriving on the expiry cycle still counts as success.
                if (tx_done) begin
                    tx_enable_d = 1'b0;
                    ack_d       = grant_onehot;
                    state_d     = ST_RELEASE;
                end else if (wd_q == WD_LAST) begin
                    tx_enable_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the frame and any ack at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            tx_data_q     <= '0;
            tx_enable_q   <= 1'b0;
            ack_q         <= '0;
            timeout_err_q <= 1'b0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            tx_data_q     <= tx_data_d;
            tx_enable_q   <= tx_enable_d;
            ack_q         <= ack_d;
            timeout_err_q <= timeout_err_d;
            wd_q          <= wd_d;
        end
    end

    assign ack         = ack_q;
    assign tx_data     = tx_data_q;
    assign tx_enable   = tx_enable_q;
    assign grant_id    = grant_id_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vectors, multi-cycle corner cases and
// a randomized run against a pending-set round-robin model.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int TMO  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [8*N-1:0]  data = '0;
  logic            tx_done = 1'b0;
  logic [N-1:0]    ack;
  logic [7:0]      tx_data;
  logic            tx_enable;
  logic [ID_W-1:0] grant_id;
  logic            busy;
  logic            timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [ID_W-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0]    req;
    int              delay;
    logic [ID_W-1:0] gid;
  } vec_t;
  vec_t tbl[10];

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data        (data),
    .ack         (ack),
    .tx_data     (tx_data),
    .tx_enable   (tx_enable),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // clock / global bound
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int g);
    return data[8*g +: 8];
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Serve one frame starting from an IDLE sample with req already driven.
  // delay = SEND cycle on which tx_done is driven (1..TMO).
  task automatic serve(input string tag, input int exp_gid, input logic [7:0] exp_byte,
                       input int delay, input bit expect_tmo, input logic [N-1:0] req_after);
    int n;
    logic [N-1:0] oh;
    oh = '0;
    oh[exp_gid] = 1'b1;
    n = 0;
    while (tx_enable !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd2);
    chk({tag, " grant_id"}, 32'(grant_id), 32'(exp_gid));
    chk({tag, " tx_data"}, 32'(tx_data), 32'(exp_byte));
    if (!expect_tmo) begin
      repeat (delay - 1) step();
      chk({tag, " enable_held"}, 32'(tx_enable), 32'd1);
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk({tag, " ack"}, 32'(ack), 32'(oh));
      chk({tag, " enable_drop"}, 32'(tx_enable), 32'd0);
    end else begin
      n = 0;
      while (tx_enable === 1'b1 && n < 40) begin
        step();
        n++;
      end
      chk({tag, " send_cycles"}, 32'(n), 32'(TMO));
      chk({tag, " no_ack"}, 32'(ack), 32'd0);
      chk({tag, " timeout_err"}, 32'(timeout_err), 32'd1);
    end
    req = req_after;
    step();
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    chk({tag, " idle_ack"}, 32'(ack), 32'd0);
  endtask

  initial begin
    logic [N-1:0] pend;
    logic [N-1:0] nb;
    logic [N-1:0] after;
    int ptr;
    int w;
    int delay;
    bit tmo;
    bit err;
    int n;

    data[7:0]   = 8'h3C;
    data[15:8]  = 8'h5A;
    data[23:16] = 8'hA5;
    data[31:24] = 8'hC3;

    // reset values
    #2 rst = 1'b1;
    step();
    step();
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst tx_data", 32'(tx_data), 32'd0);
    chk("rst tx_enable", 32'(tx_enable), 32'd0);
    chk("rst grant_id", 32'(grant_id), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    step();

    // single requester 2
    req = 4'b0100;
    serve("single", 2, 8'hA5, 1, 1'b0, 4'b0000);

    // vector table; rr_ptr is 3 after serving id 2
    tbl[0] = '{4'b1001, 3, 2'd3};
    tbl[1] = '{4'b1001, 1, 2'd0};
    tbl[2] = '{4'b0001, 2, 2'd0};
    tbl[3] = '{4'b0110, 6, 2'd1};
    tbl[4] = '{4'b0011, 1, 2'd0};
    tbl[5] = '{4'b1100, 4, 2'd2};
    tbl[6] = '{4'b1111, 2, 2'd3};
    tbl[7] = '{4'b0110, 5, 2'd1};
    tbl[8] = '{4'b1010, 3, 2'd3};
    tbl[9] = '{4'b0100, 1, 2'd2};
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req;
      serve($sformatf("vec%0d", i), int'(tbl[i].gid), byte_of(int'(tbl[i].gid)),
            tbl[i].delay, 1'b0, 4'b0000);
    end

    // rotation with everyone requesting
    reset_dut();
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      w = int'(exp_q.pop_front());
      serve($sformatf("rot%0d", i), w, byte_of(w), 5, 1'b0, (i == 4) ? 4'b0000 : 4'b1111);
    end

    // watchdog expiry then retry of the same requester (rr_ptr is 1 here)
    req = 4'b0001;
    serve("tmo", 0, 8'h3C, 0, 1'b1, 4'b0001);
    serve("retry", 0, 8'h3C, 3, 1'b0, 4'b0000);
    chk("retry sticky_err", 32'(timeout_err), 32'd1);

    // tx_done on the expiry cycle
    reset_dut();
    req = 4'b0001;
    serve("coll", 0, 8'h3C, TMO, 1'b0, 4'b0000);
    chk("coll timeout_err", 32'(timeout_err), 32'd0);

    // stray tx_done while idle
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("stray ack", 32'(ack), 32'd0);
    chk("stray busy", 32'(busy), 32'd0);
    chk("stray tx_enable", 32'(tx_enable), 32'd0);
    step();
    chk("stray ack2", 32'(ack), 32'd0);
    chk("stray busy2", 32'(busy), 32'd0);

    // async reset mid-SEND (rr_ptr is 1 here, so 1000 grants 3)
    req = 4'b1000;
    n = 0;
    while (tx_enable !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("arst pre_grant", 32'(grant_id), 32'd3);
    step();
    step();
    #3 rst = 1'b1;
    #1;
    chk("arst tx_enable", 32'(tx_enable), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst ack", 32'(ack), 32'd0);
    chk("arst grant_id", 32'(grant_id), 32'd0);
    step();
    step();
    chk("arst held_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    req = 4'b1001;
    serve("post_rst", 0, 8'h3C, 2, 1'b0, 4'b0000);

    // randomized run against a pending-set model
    reset_dut();
    pend = '0;
    ptr  = 0;
    err  = 1'b0;
    for (int it = 0; it < 40; it++) begin
      nb = N'($urandom_range(0, 15));
      if ((pend | nb) == '0) nb[$urandom_range(0, N - 1)] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (nb[i] && !pend[i]) data[8*i +: 8] = 8'($urandom_range(0, 255));
      end
      pend = pend | nb;
      req  = pend;
      w = -1;
      for (int off = 0; off < N; off++) begin
        if (w < 0 && pend[(ptr + off) % N]) w = (ptr + off) % N;
      end
      tmo   = ($urandom_range(0, 5) == 0);
      delay = $urandom_range(1, TMO);
      after = pend;
      if (!tmo) after[w] = 1'b0;
      serve($sformatf("rnd%0d", it), w, byte_of(w), delay, tmo, after);
      pend = after;
      ptr  = (w + 1) % N;
      if (tmo) err = 1'b1;
      chk($sformatf("rnd%0d err", it), 32'(timeout_err), 32'(err));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
